wb_regfile_3w4r: RTL and testbench
==================================

Name: wb_regfile_3w4r

Overview:
- Architectural integer register file that receives the three writeback ports from the EX2/WB stage:
  - port 0: pipe 0 result, CSR or divide.
  - port 1: pipe 1 result or divide.
  - port 2: dcache load return.
- Serves four combinational read ports to the issue/read-operand stage, with optional same-cycle write-to-read bypass.
- Holds a per-register pending scoreboard:
  - set when a long-latency op (divide or load) issues;
  - cleared when its writeback arrives.

Parameters:
- NREG, 32, number of architectural registers; index width AW = clog2(NREG).
- DW, 32, data width.
- BYPASS, 1, when 1 a read returns same-cycle write data; when 0 a read returns stored data only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_we0 / wb_we1 / wb_we2  in  1 each  write enables for ports 0/1/2.
- wb_rd0 / wb_rd1 / wb_rd2  in  AW each  destination register.
- wb_data0 / wb_data1 / wb_data2  in  DW each  write data.
- raddr0..raddr3  in  AW each  read addresses.
- rdata0..rdata3  out  DW each  read data (combinational).
- rbusy0..rbusy3  out  1 each  pending bit of the addressed register (combinational).
- pend_set0 / pend_set1  in  1 each  mark destination as pending (divide or load issued, pipe 0/1).
- pend_rd0 / pend_rd1  in  AW each  register to mark.
- flush  in  1  pipeline flush; clears all pending bits.
- any_pending  out  1  OR of all pending bits.

Behaviour:
- Reset:
  - all NREG registers = 0 and all pending bits = 0 on the first edge with reset=1.
  - resulting outputs: rdata* = 0 (when BYPASS=0 or no write), rbusy* = 0, any_pending = 0.
  - reset overrides writes, pend_set and flush in the same cycle.
- Register 0:
  - always reads 0, never written, never pending.
  - writes and pend_set targeting r0 are ignored.
- Write: on the edge, each port with weN=1 and rdN!=0 updates reg[rdN] <= dataN.
- Same-rd collision priority: port1 > port0 > port2.
  - pipe 1 is younger than pipe 0 in the pair.
  - a late load return belongs to an older instruction.
  - exactly one value lands; lower-priority data is dropped.
- Read:
  - rdataK = 0 if raddrK==0.
  - else, when BYPASS=1 and any enabled write targets raddrK this cycle, return the highest-priority such wb_data.
  - else return reg[raddrK].
  - no added latency.
- Pending scoreboard, per register r, next state in priority order:
  - reset -> 0;
  - else pend_set targeting r -> 1 (a new issue wins over a same-cycle writeback of the previous producer);
  - else flush -> 0;
  - else an enabled write to r on any port -> 0;
  - else hold.
  - pend_set0 and pend_set1 to the same r is legal -> 1.
- flush and pend_set in the same cycle: the set survives, because the issuing instruction belongs to the post-flush stream.
- rbusyK:
  - reflects the registered pending bit, with no bypass of same-cycle clears.
  - when BYPASS=1 and a write to raddrK occurs in the same cycle, rbusyK = 0; the data is valid via bypass.
- Writes, including during flush, always update the register array; flush affects pending bits only.
- No back-pressure: writes are always accepted.

Test Plan:
- Reset then read all: assert reset 1 cycle; raddr0..3 = 1, 5, 17, 31 -> rdata = 0, rbusy = 0, any_pending = 0.
- Triple write collision, BYPASS=1: in one cycle, wb_we0 (rd=7, 0x11111111), wb_we1 (rd=7, 0x22222222), wb_we2 (rd=7, 0x33333333), raddr0 = 7.
  - same cycle: rdata0 = 0x22222222.
  - next cycle, writes off: rdata0 = 0x22222222.
- r0 protection: wb_we2 rd=0 data=0xDEADBEEF plus pend_set0 rd=0 -> rdata(raddr=0) = 0 in both cycles; any_pending stays 0.
- Load scoreboard:
  - pend_set1 rd=9 -> next cycle rbusy(9) = 1 and any_pending = 1.
  - 3 cycles later, wb_we2 rd=9 data=0xCAFEF00D -> same-cycle rbusy = 0 and rdata = 0xCAFEF00D; next cycle pending bit = 0.
- Set/clear race: reg 4 pending; same cycle wb_we0 rd=4 (0x5) and pend_set0 rd=4 -> next cycle reg4 = 5 and rbusy(4) = 1.
- Flush: regs 3, 12, 20 pending; flush with pend_set0 rd=12 -> next cycle only r12 pending (any_pending = 1); concurrent wb_we1 rd=20 data=0xA5 still lands; rdata(20) = 0xA5.

Source files
------------

// File: rtl/wb_regfile_3w4r.sv
// Architectural integer register file: three writeback ports, four combinational
// read ports with optional write-to-read bypass, and a per-register pending scoreboard.
module wb_regfile_3w4r #(
    parameter int NREG   = 32,
    parameter int DW     = 32,
    parameter bit BYPASS = 1'b1,
    parameter int AW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_we0,
    input  logic          wb_we1,
    input  logic          wb_we2,
    input  logic [AW-1:0] wb_rd0,
    input  logic [AW-1:0] wb_rd1,
    input  logic [AW-1:0] wb_rd2,
    input  logic [DW-1:0] wb_data0,
    input  logic [DW-1:0] wb_data1,
    input  logic [DW-1:0] wb_data2,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] raddr3,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2,
    output logic [DW-1:0] rdata3,
    output logic          rbusy0,
    output logic          rbusy1,
    output logic          rbusy2,
    output logic          rbusy3,
    input  logic          pend_set0,
    input  logic          pend_set1,
    input  logic [AW-1:0] pend_rd0,
    input  logic [AW-1:0] pend_rd1,
    input  logic          flush,
    output logic          any_pending
);

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;

    logic [AW-1:0]   raddr     [4];
    logic [DW-1:0]   rdata_int [4];
    logic            rbusy_int [4];

    logic wv0;
    logic wv1;
    logic wv2;

    assign wv0 = wb_we0 && (wb_rd0 != '0);
    assign wv1 = wb_we1 && (wb_rd1 != '0);
    assign wv2 = wb_we2 && (wb_rd2 != '0);

    assign raddr[0] = raddr0;
    assign raddr[1] = raddr1;
    assign raddr[2] = raddr2;
    assign raddr[3] = raddr3;

    // Later assignments win on a shared rd, giving port1 > port0 > port2.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wv2) regs[wb_rd2] <= wb_data2;
            if (wv0) regs[wb_rd0] <= wb_data0;
            if (wv1) regs[wb_rd1] <= wb_data1;
        end
    end

    always_comb begin
        pend_nxt = pend;
        for (int unsigned r = 1; r < NREG; r++) begin
            if ((pend_set0 && (pend_rd0 == AW'(r))) ||
                (pend_set1 && (pend_rd1 == AW'(r)))) begin
                pend_nxt[r] = 1'b1;
            end else if (flush) begin
                pend_nxt[r] = 1'b0;
            end else if ((wv0 && (wb_rd0 == AW'(r))) ||
                         (wv1 && (wb_rd1 == AW'(r))) ||
                         (wv2 && (wb_rd2 == AW'(r)))) begin
                pend_nxt[r] = 1'b0;
            end
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign any_pending = |pend;

    // A bypassed read also reports not-busy since its data is already valid.
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            rdata_int[k] = regs[raddr[k]];
            rbusy_int[k] = pend[raddr[k]];
            if (BYPASS) begin
                if (wv1 && (wb_rd1 == raddr[k])) begin
                    rdata_int[k] = wb_data1;
                    rbusy_int[k] = 1'b0;
                end else if (wv0 && (wb_rd0 == raddr[k])) begin
                    rdata_int[k] = wb_data0;
                    rbusy_int[k] = 1'b0;
                end else if (wv2 && (wb_rd2 == raddr[k])) begin
                    rdata_int[k] = wb_data2;
                    rbusy_int[k] = 1'b0;
                end
            end
            if (raddr[k] == '0) begin
                rdata_int[k] = '0;
                rbusy_int[k] = 1'b0;
            end
        end
    end

    assign rdata0 = rdata_int[0];
    assign rdata1 = rdata_int[1];
    assign rdata2 = rdata_int[2];
    assign rdata3 = rdata_int[3];
    assign rbusy0 = rbusy_int[0];
    assign rbusy1 = rbusy_int[1];
    assign rbusy2 = rbusy_int[2];
    assign rbusy3 = rbusy_int[3];

endmodule

// File: tb/tb_wb_regfile_3w4r.sv
// Bench for wb_regfile_3w4r: directed scenarios plus randomized traffic against an array model.
module tb_wb_regfile_3w4r;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, we2;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic [4:0]  raddr [4];
    logic        ps0, ps1;
    logic [4:0]  prd0, prd1;
    logic        flush;
    logic [31:0] rdata0, rdata1, rdata2, rdata3;
    logic        rbusy0, rbusy1, rbusy2, rbusy3;
    logic        any_pending;
    logic [31:0] rdq [4];
    logic        rbq [4];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mreg  [32];
    logic        mpend [32];

    always #5 clk = ~clk;

    wb_regfile_3w4r #(.NREG(32), .DW(32), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .wb_we0(we0), .wb_we1(we1), .wb_we2(we2),
        .wb_rd0(rd0), .wb_rd1(rd1), .wb_rd2(rd2),
        .wb_data0(d0), .wb_data1(d1), .wb_data2(d2),
        .raddr0(raddr[0]), .raddr1(raddr[1]), .raddr2(raddr[2]), .raddr3(raddr[3]),
        .rdata0(rdata0), .rdata1(rdata1), .rdata2(rdata2), .rdata3(rdata3),
        .rbusy0(rbusy0), .rbusy1(rbusy1), .rbusy2(rbusy2), .rbusy3(rbusy3),
        .pend_set0(ps0), .pend_set1(ps1), .pend_rd0(prd0), .pend_rd1(prd1),
        .flush(flush), .any_pending(any_pending)
    );

    assign rdq[0] = rdata0;
    assign rdq[1] = rdata1;
    assign rdq[2] = rdata2;
    assign rdq[3] = rdata3;
    assign rbq[0] = rbusy0;
    assign rbq[1] = rbusy1;
    assign rbq[2] = rbusy2;
    assign rbq[3] = rbusy3;

    task automatic idle();
        reset = 1'b0; flush = 1'b0;
        we0 = 1'b0; we1 = 1'b0; we2 = 1'b0;
        rd0 = '0; rd1 = '0; rd2 = '0;
        d0 = '0; d1 = '0; d2 = '0;
        ps0 = 1'b0; ps1 = 1'b0; prd0 = '0; prd1 = '0;
    endtask

    // Expected read: youngest writer wins (pipe1, then pipe0, then load return).
    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we1 && rd1 == a) return d1;
        if (we0 && rd0 == a) return d0;
        if (we2 && rd2 == a) return d2;
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if ((we0 && rd0 == a) || (we1 && rd1 == a) || (we2 && rd2 == a)) return 1'b0;
        return mpend[a];
    endfunction

    function automatic logic exp_any();
        for (int i = 0; i < 32; i++) if (mpend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        logic [31:0] nreg [32];
        logic        set, wr;
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i] = '0;
                mpend[i] = 1'b0;
            end
            return;
        end
        nreg = mreg;
        if (we2 && rd2 != 0) nreg[rd2] = d2;
        if (we0 && rd0 != 0) nreg[rd0] = d0;
        if (we1 && rd1 != 0) nreg[rd1] = d1;
        for (int r = 1; r < 32; r++) begin
            set = (ps0 && prd0 == r) || (ps1 && prd1 == r);
            wr  = (we0 && rd0 == r) || (we1 && rd1 == r) || (we2 && rd2 == r);
            if (set)        mpend[r] = 1'b1;
            else if (flush) mpend[r] = 1'b0;
            else if (wr)    mpend[r] = 1'b0;
        end
        mreg = nreg;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        we0 = 1'b1; rd0 = 5'd5; d0 = 32'h12345678;
        ps0 = 1'b1; prd0 = 5'd5; flush = 1'b1;
        step();
        idle();
        raddr[0] = 5'd1; raddr[1] = 5'd5; raddr[2] = 5'd17; raddr[3] = 5'd31;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rdq[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata%0d got=%h exp=%h", k, rdq[k], 32'h0);
            end
            n_checks++;
            if (rbq[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_rbusy%0d got=%b exp=0", k, rbq[k]);
            end
        end
        n_checks++;
        if (any_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_any_pending got=%b exp=0", any_pending);
        end
    endtask

    task automatic test_triple_collision();
        idle();
        we0 = 1'b1; rd0 = 5'd7; d0 = 32'h11111111;
        we1 = 1'b1; rd1 = 5'd7; d1 = 32'h22222222;
        we2 = 1'b1; rd2 = 5'd7; d2 = 32'h33333333;
        raddr[0] = 5'd7;
        #1;
        n_checks++;
        if (rdata0 !== 32'h22222222) begin
            n_fail++;
            $display("FAIL triple_bypass got=%h exp=%h", rdata0, 32'h22222222);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (rdata0 !== 32'h22222222) begin
            n_fail++;
            $display("FAIL triple_stored got=%h exp=%h", rdata0, 32'h22222222);
        end
    endtask

    task automatic test_r0();
        idle();
        we2 = 1'b1; rd2 = 5'd0; d2 = 32'hDEADBEEF;
        ps0 = 1'b1; prd0 = 5'd0;
        raddr[0] = 5'd0;
        #1;
        n_checks++;
        if (rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_same_cycle got=%h exp=%h", rdata0, 32'h0);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (rdata0 !== 32'h0) begin
            n_fail++;
            $display("FAIL r0_next_cycle got=%h exp=%h", rdata0, 32'h0);
        end
        n_checks++;
        if (any_pending !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_any_pending got=%b exp=0", any_pending);
        end
    endtask

    task automatic test_load_scoreboard();
        idle();
        ps1 = 1'b1; prd1 = 5'd9;
        step();
        idle();
        raddr[0] = 5'd9;
        #1;
        n_checks++;
        if (rbusy0 !== 1'b1 || any_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL load_set got=%b/%b exp=1/1", rbusy0, any_pending);
        end
        step();
        step();
        we2 = 1'b1; rd2 = 5'd9; d2 = 32'hCAFEF00D;
        #1;
        n_checks++;
        if (rbusy0 !== 1'b0 || rdata0 !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL load_return got=%b/%h exp=0/%h", rbusy0, rdata0, 32'hCAFEF00D);
        end
        step();
        idle();
        #1;
        n_checks++;
        if (rbusy0 !== 1'b0 || any_pending !== 1'b0 || rdata0 !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL load_cleared got=%b/%b/%h exp=0/0/%h", rbusy0, any_pending, rdata0, 32'hCAFEF00D);
        end
    endtask

    task automatic test_set_clear_race();
        idle();
        ps0 = 1'b1; prd0 = 5'd4;
        step();
        idle();
        we0 = 1'b1; rd0 = 5'd4; d0 = 32'h5;
        ps0 = 1'b1; prd0 = 5'd4;
        step();
        idle();
        raddr[0] = 5'd4;
        #1;
        n_checks++;
        if (rdata0 !== 32'h5 || rbusy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL race got=%h/%b exp=%h/1", rdata0, rbusy0, 32'h5);
        end
    endtask

    task automatic test_flush();
        idle();
        ps0 = 1'b1; prd0 = 5'd3; ps1 = 1'b1; prd1 = 5'd12;
        step();
        idle();
        ps0 = 1'b1; prd0 = 5'd20;
        step();
        idle();
        flush = 1'b1; ps0 = 1'b1; prd0 = 5'd12;
        we1 = 1'b1; rd1 = 5'd20; d1 = 32'hA5;
        raddr[0] = 5'd3; raddr[1] = 5'd12; raddr[2] = 5'd20; raddr[3] = 5'd4;
        #1;
        n_checks++;
        if (rdata2 !== 32'hA5 || rbusy2 !== 1'b0 || rbusy0 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_same_cycle got=%h/%b/%b exp=%h/0/1", rdata2, rbusy2, rbusy0, 32'hA5);
        end
        step();
        idle();
        #1;
        n_checks++;
        if ({rbusy0, rbusy1, rbusy2, rbusy3} !== 4'b0100 || any_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pending got=%b%b%b%b/%b exp=0100/1", rbusy0, rbusy1, rbusy2, rbusy3, any_pending);
        end
        n_checks++;
        if (rdata2 !== 32'hA5) begin
            n_fail++;
            $display("FAIL flush_write got=%h exp=%h", rdata2, 32'hA5);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 400; it++) begin
            idle();
            reset = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 14) == 0);
            we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1); we2 = $urandom_range(0, 1);
            rd0 = 5'($urandom_range(0, 7)); rd1 = 5'($urandom_range(0, 7)); rd2 = 5'($urandom_range(0, 31));
            d0 = $urandom; d1 = $urandom; d2 = $urandom;
            ps0 = ($urandom_range(0, 3) == 0); ps1 = ($urandom_range(0, 3) == 0);
            prd0 = 5'($urandom_range(0, 7)); prd1 = 5'($urandom_range(0, 31));
            for (int k = 0; k < 4; k++) begin
                raddr[k] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            #1;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (rdq[k] !== exp_data(raddr[k]) || rbq[k] !== exp_busy(raddr[k])) begin
                    n_fail++;
                    $display("FAIL rand_read it=%0d port=%0d addr=%0d got=%h/%b exp=%h/%b",
                             it, k, raddr[k], rdq[k], rbq[k], exp_data(raddr[k]), exp_busy(raddr[k]));
                end
            end
            n_checks++;
            if (any_pending !== exp_any()) begin
                n_fail++;
                $display("FAIL rand_any_pending it=%0d got=%b exp=%b", it, any_pending, exp_any());
            end
            step();
        end
    endtask

    initial begin
        idle();
        for (int k = 0; k < 4; k++) raddr[k] = '0;
        #2;
        test_reset();
        test_triple_collision();
        test_r0();
        test_load_scoreboard();
        test_set_clear_race();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
